// File: rtl/dr_channel_arbiter.sv
// -----------------------------------------------------------------------------
// dr_channel_arbiter
//   Round-robin arbiter that shares one dual-rail (dt/df) four-phase
//   return-to-zero channel among N_REQ single-rail requesters. A granted word
//   is driven as a dual-rail codeword (dt = word, df = ~word) and held until the
//   stage acknowledges it. The rails then return to the all-zero spacer, and the
//   arbiter waits for the acknowledge to drop. A watchdog aborts stalled
//   handshakes.
//
// Ports
//   clk          single clock
//   reset        asynchronous, active-high
//   req_valid    [N_REQ]       requester i has a word pending
//   req_data     [N_REQ*BIT0]  requester i word at [i*BIT0 +: BIT0]
//   req_accept   [N_REQ]       one-hot, one-cycle pulse: word i captured
//   halt                       blocks new grants (checked in IDLE only)
//   dt_0 / df_0  [BIT0]        true / false rails
//   ack_nxt                    stage acknowledge, asynchronous to clk
//   grant_id     [ID_W]        index of current/last grant
//   busy                       handshake in progress (DATA or NULL)
//   txn_done                   one-cycle pulse on clean completion
//   err_timeout                sticky stall flag, cleared by reset only
// -----------------------------------------------------------------------------
module dr_channel_arbiter #(
    parameter int  N_REQ       = 4,
    parameter int  BIT0        = 8,
    parameter int  SYNC_STAGES = 2,
    parameter int  TIMEOUT     = 64,
    localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*BIT0-1:0] req_data,
    output logic [N_REQ-1:0]      req_accept,
    input  logic                  halt,
    output logic [BIT0-1:0]       dt_0,
    output logic [BIT0-1:0]       df_0,
    input  logic                  ack_nxt,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic                  txn_done,
    output logic                  err_timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_NULL
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_warm;
    logic                   w_ack_s;
    logic                   w_ready;
    logic [ID_W-1:0]        r_ptr, w_ptr_nxt;
    logic [ID_W-1:0]        r_gid, w_gid_nxt;
    logic [ID_W-1:0]        w_idx;
    logic [ID_W:0]          w_cand;
    logic                   w_found;
    logic [BIT0-1:0]        r_dt, w_dt_nxt;
    logic [BIT0-1:0]        r_df, w_df_nxt;
    logic [N_REQ-1:0]       r_accept, w_accept_nxt;
    logic                   r_busy;
    logic                   r_done, w_done_nxt;
    logic                   r_err, w_err_nxt;
    logic                   r_ack_seen, w_ack_seen_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic                   w_tmo;

    // Acknowledge synchroniser. r_warm fills with ones alongside it: the sync
    // flops come out of reset at 0, which would otherwise look like "stage at
    // spacer" before the real ack level has propagated through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_warm <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the values from before the edge.
            r_sync <= {r_sync[SYNC_STAGES-2:0], ack_nxt};
            r_warm <= {r_warm[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_ack_s = r_sync[SYNC_STAGES-1];
    assign w_ready = r_warm[SYNC_STAGES-1];

    // First valid requester at or after r_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(N_REQ)) begin
                w_cand = w_cand - (ID_W+1)'(N_REQ);
            end
            if (!w_found && req_valid[w_cand[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[ID_W-1:0];
            end
        end
    end

    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        w_state_nxt    = r_state;
        w_dt_nxt       = r_dt;
        w_df_nxt       = r_df;
        w_accept_nxt   = '0;
        w_gid_nxt      = r_gid;
        w_ptr_nxt      = r_ptr;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;
        w_ack_seen_nxt = r_ack_seen;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_ready && !halt && w_found && !w_ack_s) begin
                    w_dt_nxt       = req_data[w_idx*BIT0 +: BIT0];
                    w_df_nxt       = ~req_data[w_idx*BIT0 +: BIT0];
                    w_gid_nxt      = w_idx;
                    w_accept_nxt   = N_REQ'(1) << w_idx;
                    w_ptr_nxt      = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
                    w_ack_seen_nxt = 1'b0;
                    w_state_nxt    = S_DATA;
                end
            end
            S_DATA: begin
                if (w_ack_s) begin
                    w_dt_nxt       = '0;
                    w_df_nxt       = '0;
                    w_cnt_nxt      = '0;
                    w_ack_seen_nxt = 1'b1;
                    w_state_nxt    = S_NULL;
                end else if (w_tmo) begin
                    // Stage never answered: withdraw the codeword anyway.
                    w_err_nxt      = 1'b1;
                    w_dt_nxt       = '0;
                    w_df_nxt       = '0;
                    w_cnt_nxt      = '0;
                    w_ack_seen_nxt = 1'b0;
                    w_state_nxt    = S_NULL;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_NULL: begin
                // Completion needs an ack high-then-low; after a forced spacer
                // the ack was never seen high, so a low ack alone is not a
                // finished handshake and only the watchdog can leave.
                if (r_ack_seen && !w_ack_s) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_ack_s) begin
                        w_ack_seen_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dt       <= '0;
            r_df       <= '0;
            r_accept   <= '0;
            r_gid      <= '0;
            r_ptr      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ack_seen <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dt       <= w_dt_nxt;
            r_df       <= w_df_nxt;
            r_accept   <= w_accept_nxt;
            r_gid      <= w_gid_nxt;
            r_ptr      <= w_ptr_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_ack_seen <= w_ack_seen_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign dt_0        = r_dt;
    assign df_0        = r_df;
    assign req_accept  = r_accept;
    assign grant_id    = r_gid;
    assign busy        = r_busy;
    assign txn_done    = r_done;
    assign err_timeout = r_err;

endmodule
